// File: rtl/branch_predict_eval.sv
// -----------------------------------------------------------------------------
// branch_predict_eval
//
// Execute-stage branch evaluation unit. It resolves the branch condition from
// the ALU result, compares the outcome with the prediction that travelled down
// the pipe, and keeps a direct-mapped table of saturating-counter predictors.
// Fetch reads that table through a registered prediction port. Two saturating
// statistics counters track resolved conditional branches and mispredictions.
//
// Ports
//   clk             rising-edge clock
//   rstn            asynchronous active-low reset
//   pred_valid      fetch requests a prediction this cycle
//   pred_pc         PC of the fetched instruction
//   pred_out_valid  registered: prediction available (one cycle after request)
//   pred_taken      registered: predicted direction (holds when no request)
//   res_valid       a branch or jump resolves this cycle
//   res_pc          PC of the resolving instruction
//   ALU_Out         ALU result feeding the condition
//   Cond            0 = NE (non-branch), 1 = ALU (taken if ALU_Out != 0),
//                   2 = NALU (taken if ALU_Out == 0), 3 = AL (always taken)
//   res_pred_taken  prediction carried with the resolving instruction
//   branch_taken    combinational resolved direction, 0 when res_valid = 0
//   mispredict      registered one-cycle pulse for the flush logic
//   stat_clr        synchronous clear of both statistics counters
//   branch_cnt      saturating count of table updates (ALU/NALU resolves)
//   mispred_cnt     saturating count of mispredictions (AL included)
//
// Handshake semantics: pred_valid and res_valid are single-cycle qualifiers
// with no backpressure. Each cycle in which a valid is high is exactly one
// request; the unit always accepts it. pred_out_valid is high for exactly the
// one cycle following an accepted prediction request.
// -----------------------------------------------------------------------------
module branch_predict_eval #(
  parameter int WordSize    = 32,
  parameter int IndexBits   = 6,
  parameter int CounterBits = 2,
  parameter int StatBits    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                pred_valid,
  input  logic [WordSize-1:0] pred_pc,
  output logic                pred_out_valid,
  output logic                pred_taken,
  input  logic                res_valid,
  input  logic [WordSize-1:0] res_pc,
  input  logic [WordSize-1:0] ALU_Out,
  input  logic [1:0]          Cond,
  input  logic                res_pred_taken,
  output logic                branch_taken,
  output logic                mispredict,
  input  logic                stat_clr,
  output logic [StatBits-1:0] branch_cnt,
  output logic [StatBits-1:0] mispred_cnt
);

  localparam int Entries = 1 << IndexBits;

  localparam logic [1:0] CondNe   = 2'd0;
  localparam logic [1:0] CondAlu  = 2'd1;
  localparam logic [1:0] CondNalu = 2'd2;
  localparam logic [1:0] CondAl   = 2'd3;

  // Counters reset to "weakly not-taken": the largest value whose MSB is 0.
  localparam logic [CounterBits-1:0] CntInit = CounterBits'((1 << (CounterBits - 1)) - 1);
  localparam logic [CounterBits-1:0] CntMax  = '1;
  localparam logic [CounterBits-1:0] CntZero = '0;
  localparam logic [CounterBits-1:0] CntOne  = CounterBits'(1);

  localparam logic [StatBits-1:0] StatMax = '1;
  localparam logic [StatBits-1:0] StatOne = StatBits'(1);

  // ---------------------------------------------------------------------------
  // Index extraction. Bits [1:0] and everything above IndexBits+1 are dropped
  // on purpose, so PCs differing only there alias onto one entry.
  // ---------------------------------------------------------------------------
  logic [IndexBits-1:0] pred_idx;
  logic [IndexBits-1:0] res_idx;

  assign pred_idx = pred_pc[IndexBits+1:2];
  assign res_idx  = res_pc[IndexBits+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[WordSize-1:IndexBits+2], pred_pc[1:0],
                            res_pc[WordSize-1:IndexBits+2], res_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Predictor table storage
  // ---------------------------------------------------------------------------
  logic [CounterBits-1:0] table_q [Entries];

  // ---------------------------------------------------------------------------
  // Resolution: purely combinational so the flush decision can be registered
  // in the same cycle the branch resolves.
  // ---------------------------------------------------------------------------
  logic cond_true;

  always_comb begin
    cond_true = 1'b0;
    case (Cond)
      CondAlu:  cond_true = |ALU_Out;
      CondNalu: cond_true = ~|ALU_Out;
      CondAl:   cond_true = 1'b1;
      default:  cond_true = 1'b0;
    endcase
    branch_taken = res_valid & cond_true;
  end

  // Non-branches never mispredict whatever prediction they carry; jumps do
  // when fetch guessed not-taken.
  logic mispred_cond;
  assign mispred_cond = res_valid && (Cond != CondNe) && (branch_taken != res_pred_taken);

  // Only true conditional branches train the table; jumps are always taken and
  // would just push entries toward taken without telling us anything.
  logic update_en;
  assign update_en = res_valid && ((Cond == CondAlu) || (Cond == CondNalu));

  // ---------------------------------------------------------------------------
  // Next value of the entry being trained (saturating, never wraps)
  // ---------------------------------------------------------------------------
  logic [CounterBits-1:0] cnt_cur;
  logic [CounterBits-1:0] cnt_next;

  always_comb begin
    cnt_cur  = table_q[res_idx];
    cnt_next = cnt_cur;
    if (branch_taken) begin
      if (cnt_cur != CntMax) begin
        cnt_next = cnt_cur + CntOne;
      end
    end else begin
      if (cnt_cur != CntZero) begin
        cnt_next = cnt_cur - CntOne;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Table update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      table_q <= '{default: CntInit};
    end else if (update_en) begin
      table_q[res_idx] <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Prediction port. The read uses table_q as it stands before this edge, so a
  // same-cycle update to the same entry is not visible until the next request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
    end else begin
      pred_out_valid <= pred_valid;
      if (pred_valid) begin
        pred_taken <= table_q[pred_idx][CounterBits-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mispredict pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mispredict <= 1'b0;
    end else begin
      mispredict <= mispred_cond;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics. Clear wins over a same-cycle increment; both counters stick
  // at all-ones rather than wrapping back to a misleading small value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (stat_clr) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (update_en && (branch_cnt != StatMax)) begin
        branch_cnt <= branch_cnt + StatOne;
      end
      if (mispred_cond && (mispred_cnt != StatMax)) begin
        mispred_cnt <= mispred_cnt + StatOne;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_eval.sv
module tb_branch_predict_eval;

  localparam int WS = 32;
  localparam int IB = 6;
  localparam int CB = 2;
  localparam int SB = 4;

  localparam logic [1:0] C_NE   = 2'd0;
  localparam logic [1:0] C_ALU  = 2'd1;
  localparam logic [1:0] C_NALU = 2'd2;
  localparam logic [1:0] C_AL   = 2'd3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          pred_valid;
  logic [WS-1:0] pred_pc;
  logic          pred_out_valid;
  logic          pred_taken;
  logic          res_valid;
  logic [WS-1:0] res_pc;
  logic [WS-1:0] ALU_Out;
  logic [1:0]    Cond;
  logic          res_pred_taken;
  logic          branch_taken;
  logic          mispredict;
  logic          stat_clr;
  logic [SB-1:0] branch_cnt;
  logic [SB-1:0] mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predict_eval #(
    .WordSize(WS), .IndexBits(IB), .CounterBits(CB), .StatBits(SB)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_out_valid (pred_out_valid),
    .pred_taken     (pred_taken),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .ALU_Out        (ALU_Out),
    .Cond           (Cond),
    .res_pred_taken (res_pred_taken),
    .branch_taken   (branch_taken),
    .mispredict     (mispredict),
    .stat_clr       (stat_clr),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    pred_valid     = 1'b0;
    pred_pc        = '0;
    res_valid      = 1'b0;
    res_pc         = '0;
    ALU_Out        = '0;
    Cond           = C_NE;
    res_pred_taken = 1'b0;
    stat_clr       = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // One resolve cycle: checks the combinational direction before the edge and
  // the registered mispredict pulse after it.
  task automatic resolve(input logic [WS-1:0] pc, input logic [1:0] c,
                         input logic [WS-1:0] alu, input logic rpt,
                         input logic exp_bt, input logic exp_mp, input string name);
    res_valid      = 1'b1;
    res_pc         = pc;
    Cond           = c;
    ALU_Out        = alu;
    res_pred_taken = rpt;
    #1;
    n_checks++;
    if (branch_taken !== exp_bt) begin
      n_fail++;
      $display("FAIL %s branch_taken: got %0b want %0b", name, branch_taken, exp_bt);
    end
    @(posedge clk);
    #1;
    res_valid      = 1'b0;
    res_pred_taken = 1'b0;
    n_checks++;
    if (mispredict !== exp_mp) begin
      n_fail++;
      $display("FAIL %s mispredict: got %0b want %0b", name, mispredict, exp_mp);
    end
  endtask

  task automatic predict(input logic [WS-1:0] pc, input logic exp_taken, input string name);
    pred_valid = 1'b1;
    pred_pc    = pc;
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    n_checks++;
    if (pred_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s pred_out_valid: got %0b want 1", name, pred_out_valid);
    end
    n_checks++;
    if (pred_taken !== exp_taken) begin
      n_fail++;
      $display("FAIL %s pred_taken: got %0b want %0b", name, pred_taken, exp_taken);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({pred_out_valid, pred_taken, mispredict, branch_taken} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {pred_out_valid, pred_taken, mispredict, branch_taken});
    end
    n_checks++;
    if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d/%0d want 0/0", branch_cnt, mispred_cnt);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_prediction();
    predict(32'h100, 1'b0, "pred_initial");
    @(posedge clk);
    #1;
    n_checks++;
    if (pred_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pred_idle_valid: got %0b want 0", pred_out_valid);
    end
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL pred_idle_hold: got %0b want 0", pred_taken);
    end
  endtask

  task automatic test_counter_saturation();
    // 1 -> 2 -> 3 -> 3 (sat) -> 3 (sat)
    for (int i = 0; i < 4; i++) begin
      resolve(32'h100, C_ALU, 32'd5, 1'b0, 1'b1, 1'b1, "taken_train");
    end
    n_checks++;
    if (branch_cnt !== 4'd4 || mispred_cnt !== 4'd4) begin
      n_fail++;
      $display("FAIL train_stats: got %0d/%0d want 4/4", branch_cnt, mispred_cnt);
    end
    predict(32'h100, 1'b1, "pred_after_train");
    @(posedge clk);
    #1;
    n_checks++;
    if (pred_out_valid !== 1'b0 || pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL pred_hold_taken: got valid=%0b taken=%0b want valid=0 taken=1",
               pred_out_valid, pred_taken);
    end
    // 3 -> 2: still predicts taken only if the upper end saturated instead of wrapping
    resolve(32'h100, C_ALU, 32'd0, 1'b1, 1'b0, 1'b1, "nt_from_3");
    predict(32'h100, 1'b1, "pred_entry2");
    resolve(32'h100, C_ALU, 32'd0, 1'b1, 1'b0, 1'b1, "nt_from_2");
    predict(32'h100, 1'b0, "pred_entry1");
    // 1 -> 0 -> 0 (sat), correctly predicted not-taken
    resolve(32'h100, C_ALU, 32'd0, 1'b0, 1'b0, 1'b0, "nt_from_1");
    resolve(32'h100, C_ALU, 32'd0, 1'b0, 1'b0, 1'b0, "nt_sat_0");
    // 0 -> 1; only the MSB of ALU_Out is set
    resolve(32'h100, C_ALU, 32'h8000_0000, 1'b1, 1'b1, 1'b0, "taken_msb");
    predict(32'h100, 1'b0, "pred_after_low_sat");
    resolve(32'h100, C_ALU, 32'd1, 1'b0, 1'b1, 1'b1, "taken_to_2");
    predict(32'h100, 1'b1, "pred_back_to_2");
    n_checks++;
    if (branch_cnt !== 4'd10 || mispred_cnt !== 4'd7) begin
      n_fail++;
      $display("FAIL sat_stats: got %0d/%0d want 10/7", branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_nalu_ne();
    apply_reset();
    // Idle resolve port reports not-taken even for an unconditional Cond.
    Cond = C_AL;
    #1;
    n_checks++;
    if (branch_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_not_taken: got %0b want 0", branch_taken);
    end
    Cond = C_NE;
    resolve(32'h140, C_NALU, 32'd0, 1'b1, 1'b1, 1'b0, "nalu_taken");
    resolve(32'h140, C_NE,   32'd0, 1'b1, 1'b0, 1'b0, "ne_zero");
    resolve(32'h140, C_NE,   32'd7, 1'b1, 1'b0, 1'b0, "ne_nonzero");
    n_checks++;
    if (branch_cnt !== 4'd1 || mispred_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL ne_stats: got %0d/%0d want 1/0", branch_cnt, mispred_cnt);
    end
    predict(32'h140, 1'b1, "pred_after_nalu");
    resolve(32'h180, C_NALU, 32'd3, 1'b0, 1'b0, 1'b0, "nalu_not_taken");
    predict(32'h180, 1'b0, "pred_after_nalu_nt");
    n_checks++;
    if (branch_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL nalu_branch_cnt: got %0d want 2", branch_cnt);
    end
  endtask

  task automatic test_jump();
    apply_reset();
    resolve(32'h200, C_AL, 32'd0, 1'b0, 1'b1, 1'b1, "al_mispred");
    n_checks++;
    if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL al_stats: got %0d/%0d want 0/1", branch_cnt, mispred_cnt);
    end
    resolve(32'h200, C_AL, 32'd0, 1'b1, 1'b1, 1'b0, "al_correct");
    predict(32'h200, 1'b0, "pred_after_al");
    // Entry must still be 1: one taken update lands on 2.
    resolve(32'h200, C_ALU, 32'd9, 1'b1, 1'b1, 1'b0, "alu_after_al");
    predict(32'h200, 1'b1, "pred_al_untouched");
    n_checks++;
    if (branch_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL al_final_stats: got %0d/%0d want 1/1", branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_back_to_back_same_index();
    apply_reset();
    pred_valid     = 1'b1;
    pred_pc        = 32'h104;
    res_valid      = 1'b1;
    res_pc         = 32'h104;
    Cond           = C_ALU;
    ALU_Out        = 32'd1;
    res_pred_taken = 1'b0;
    @(posedge clk);
    #1;
    idle_inputs();
    n_checks++;
    if (pred_out_valid !== 1'b1 || pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_read: got valid=%0b taken=%0b want valid=1 taken=0",
               pred_out_valid, pred_taken);
    end
    n_checks++;
    if (mispredict !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_mispredict: got %0b want 1", mispredict);
    end
    predict(32'h104, 1'b1, "pred_after_commit");
    predict(32'h204, 1'b1, "alias_high_bit");
    predict(32'h107, 1'b1, "alias_low_bits");
    predict(32'h108, 1'b0, "neighbour_entry");
  endtask

  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      resolve(32'h300, C_AL, 32'd0, 1'b0, 1'b1, 1'b1, "al_sat_loop");
      if (i == 14) begin
        n_checks++;
        if (mispred_cnt !== 4'd15) begin
          n_fail++;
          $display("FAIL mispred_at_15: got %0d want 15", mispred_cnt);
        end
      end
    end
    n_checks++;
    if (mispred_cnt !== 4'd15 || branch_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL mispred_sat: got %0d/%0d want branch 0 mispred 15", branch_cnt, mispred_cnt);
    end
    for (int i = 0; i < 17; i++) begin
      resolve(32'h300, C_ALU, 32'd1, 1'b1, 1'b1, 1'b0, "alu_sat_loop");
    end
    n_checks++;
    if (branch_cnt !== 4'd15 || mispred_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL branch_sat: got %0d/%0d want 15/15", branch_cnt, mispred_cnt);
    end
    stat_clr = 1'b1;
    resolve(32'h300, C_ALU, 32'd0, 1'b1, 1'b0, 1'b1, "clr_with_mispred");
    stat_clr = 1'b0;
    n_checks++;
    if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL stat_clr_priority: got %0d/%0d want 0/0", branch_cnt, mispred_cnt);
    end
    resolve(32'h300, C_AL, 32'd0, 1'b0, 1'b1, 1'b1, "count_after_clr");
    n_checks++;
    if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL count_after_clr: got %0d/%0d want 0/1", branch_cnt, mispred_cnt);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    resolve(32'h100, C_ALU, 32'd1, 1'b0, 1'b1, 1'b1, "pre_reset_1");
    resolve(32'h100, C_ALU, 32'd1, 1'b0, 1'b1, 1'b1, "pre_reset_2");
    pred_valid     = 1'b1;
    pred_pc        = 32'h100;
    res_valid      = 1'b1;
    res_pc         = 32'h100;
    Cond           = C_ALU;
    ALU_Out        = 32'd1;
    res_pred_taken = 1'b0;
    @(posedge clk);
    #1;
    idle_inputs();
    n_checks++;
    if ({pred_out_valid, pred_taken, mispredict} !== 3'b111 ||
        branch_cnt !== 4'd3 || mispred_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL pre_reset_state: got flags=%b cnt=%0d/%0d want flags=111 cnt=3/3",
               {pred_out_valid, pred_taken, mispredict}, branch_cnt, mispred_cnt);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({pred_out_valid, pred_taken, mispredict} !== 3'b000 ||
        branch_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got flags=%b cnt=%0d/%0d want flags=000 cnt=0/0",
               {pred_out_valid, pred_taken, mispredict}, branch_cnt, mispred_cnt);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    predict(32'h100, 1'b0, "pred_after_mid_reset");
    // Entry back at 1: one taken step reaches 2 (taken), proving it was not left at 0.
    resolve(32'h100, C_ALU, 32'd1, 1'b0, 1'b1, 1'b1, "post_reset_train");
    predict(32'h100, 1'b1, "pred_post_reset_train");
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_prediction();
    test_counter_saturation();
    test_nalu_ne();
    test_jump();
    test_back_to_back_same_index();
    test_stats();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_eval.md
Name: branch_predict_eval

Overview:
- Second-generation branch evaluation unit for the execute stage.
- Evaluates the resolved branch condition from the ALU result and compares it with the fetch-stage prediction.
- Maintains a parametrised table of saturating-counter predictors, a registered prediction port for fetch, and saturating statistics counters.
- Registered mispredict pulse drives the pipeline flush logic.

Parameters:
- WordSize, 32, width of ALU result and PC.
- IndexBits, 6, log2 of predictor table entries; index = pc[IndexBits+1:2].
- CounterBits, 2, width of each saturating counter (must be >= 1).
- StatBits, 16, width of each statistics counter.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- pred_valid  input  1  fetch requests a prediction this cycle.
- pred_pc  input  WordSize  PC of the fetched instruction.
- pred_out_valid  output  1  registered: prediction available (one cycle after pred_valid).
- pred_taken  output  1  registered: predicted direction.
- res_valid  input  1  a branch or jump is resolving this cycle.
- res_pc  input  WordSize  PC of the resolving instruction.
- ALU_Out  input  WordSize  ALU result for the condition.
- Cond  input  2  0 = NE (non-branch), 1 = ALU (taken if ALU_Out != 0), 2 = NALU (taken if ALU_Out == 0), 3 = AL (jump, always taken).
- res_pred_taken  input  1  prediction carried down the pipe with the instruction.
- branch_taken  output  1  combinational resolved direction; 0 when res_valid = 0.
- mispredict  output  1  registered one-cycle pulse.
- stat_clr  input  1  synchronous clear of statistics.
- branch_cnt  output  StatBits  count of resolved conditional branches.
- mispred_cnt  output  StatBits  count of mispredictions.

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - Reset is asynchronous and active-low (rstn).
  - During reset every counter entry = 2^(CounterBits-1) - 1 (weakly not-taken; 1 for 2-bit).
  - Reset values: pred_out_valid = 0, pred_taken = 0, mispredict = 0, branch_cnt = 0, mispred_cnt = 0.
  - Reset asserted mid-operation discards all in-flight state; the first edge after release behaves as a fresh start.
- Prediction path (1-cycle latency):
  - On an edge with pred_valid = 1: pred_taken <= MSB of entry[pred_pc index]; pred_out_valid <= 1.
  - On an edge with pred_valid = 0: pred_out_valid <= 0 and pred_taken holds its value.
- Resolution (combinational):
  - branch_taken = res_valid & (Cond==ALU ? |ALU_Out : Cond==NALU ? ~|ALU_Out : Cond==AL).
  - Cond = NE never reports taken.
- Mispredict (registered):
  - mispredict <= res_valid & (Cond != NE) & (branch_taken != res_pred_taken).
  - AL with res_pred_taken = 0 is a mispredict.
  - NE never mispredicts, regardless of res_pred_taken.
- Table update, on an edge with res_valid = 1 and Cond in {ALU, NALU} only:
  - Entry at res_pc index increments if taken and decrements if not.
  - Saturates at 0 and at 2^CounterBits - 1; no wrap.
  - AL and NE leave the table untouched.
- Same-cycle predict and update:
  - If pred_valid and an update target the same index in one cycle, the prediction uses the pre-update value (read-before-write).
  - The update still commits.
- Statistics:
  - branch_cnt increments on each table update event.
  - mispred_cnt increments on each edge where the mispredict condition is true (including AL).
  - Both saturate at all-ones and hold there.
  - stat_clr = 1 forces both to 0 on the next edge and takes priority over a same-cycle increment.
- Width and aliasing: PC bits above IndexBits+1 and bits [1:0] are ignored, so PCs that differ only there share an entry.

Test Plan:
- Reset, then pred_valid = 1 with pred_pc = 0x100 -> next cycle pred_out_valid = 1, pred_taken = 0; following idle cycle pred_out_valid = 0 and pred_taken stays 0.
- Three resolves at res_pc = 0x100, Cond = ALU, ALU_Out = 5, res_pred_taken = 0 -> branch_taken = 1 each time; mispredict pulses on all three; entry steps 1 -> 2 -> 3 and holds at 3 on a fourth; predict at 0x100 then returns 1; branch_cnt = 4, mispred_cnt = 4.
- Cond = NALU with ALU_Out = 0 and res_pred_taken = 1 -> branch_taken = 1, no mispredict. Cond = NE with res_pred_taken = 1 -> branch_taken = 0, no mispredict, table and branch_cnt unchanged.
- Cond = AL with res_pred_taken = 0 at 0x200 -> mispredict pulse, mispred_cnt + 1, branch_cnt unchanged, entry at 0x200 stays 1.
- Same-cycle pred_pc = res_pc = 0x104, entry = 1, taken ALU resolve -> pred_taken = 0 (old value); the next predict at 0x104 returns 1. Aliasing check: 0x104 + (1 << (IndexBits+2)) reads the same entry.
- StatBits = 4: drive 17 mispredicts -> mispred_cnt saturates at 15. stat_clr asserted together with a mispredict -> both counters read 0. rstn pulsed mid-stream -> all outputs and table entries return to reset values immediately.
